// File: rtl/spi_slave_if.sv
// Byte-level and pin-level signals of one SPI slave endpoint.
interface spi_slave_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] slaveDataToSend;
    logic             load;
    logic [WIDTH-1:0] slaveDataReceived;
    logic             rxValid;
    logic             busy;
    logic             SCLK;
    logic             CS;
    logic             MOSI;
    logic             MISO;

    modport slave (
        input  slaveDataToSend, load, SCLK, CS, MOSI,
        output slaveDataReceived, rxValid, busy, MISO
    );

    modport master (
        output slaveDataToSend, load, SCLK, CS, MOSI,
        input  slaveDataReceived, rxValid, busy, MISO
    );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, oversampled on the system clock.
// Receives a WIDTH-bit word on MOSI while returning the TX buffer on MISO;
// supports back-to-back words while CS stays low.
module spi_slave #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    spi_slave_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, ABORT} state_t;

    state_t state, stateNext;

    logic [SYNC_STAGES-1:0] sclkSync, csSync, mosiSync;
    logic                   sclkDly, csDly;
    logic                   sclkS, csS, mosiS;
    logic                   sclkRise, sclkFall, csRise, csFall;

    logic [WIDTH-1:0] txBuf, txShift, rxShift, rxData, txSrc;
    logic [CW-1:0]    cnt;
    logic             reload, rxValidReg, misoReg;

    assign sclkS    = sclkSync[SYNC_STAGES-1];
    assign csS      = csSync[SYNC_STAGES-1];
    assign mosiS    = mosiSync[SYNC_STAGES-1];
    assign sclkRise = sclkS & ~sclkDly;
    assign sclkFall = ~sclkS & sclkDly;
    assign csRise   = csS & ~csDly;
    assign csFall   = ~csS & csDly;

    // A load in the same cycle as a word boundary wins over the stored buffer.
    assign txSrc = bus.load ? bus.slaveDataToSend : txBuf;

    assign bus.slaveDataReceived = rxData;
    assign bus.rxValid           = rxValidReg;
    assign bus.busy              = ~csS;
    assign bus.MISO              = misoReg;

    // Pin synchronisers plus one extra SCLK/CS copy for edge detection.
    // CS resets high so the bus reads as deselected out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclkSync <= '0;
            csSync   <= '1;
            mosiSync <= '0;
            sclkDly  <= 1'b0;
            csDly    <= 1'b1;
        end else begin
            sclkSync[0] <= bus.SCLK;
            csSync[0]   <= bus.CS;
            mosiSync[0] <= bus.MOSI;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclkSync[i] <= sclkSync[i-1];
                csSync[i]   <= csSync[i-1];
                mosiSync[i] <= mosiSync[i-1];
            end
            sclkDly <= sclkS;
            csDly   <= csS;
        end
    end

    // TX buffer captures every load strobe; the shifter picks it up at word boundaries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) txBuf <= '0;
        else if (bus.load) txBuf <= bus.slaveDataToSend;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Next-state logic: a CS rise mid-word (counter non-zero) aborts the word.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (csFall) stateNext = SHIFT;
            SHIFT:   if (csRise) stateNext = (cnt == '0) ? IDLE : ABORT;
            ABORT:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Shift datapath: sample MOSI on SCLK rise, advance MISO on SCLK fall.
    // CS rise takes priority over any SCLK edge seen in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txShift    <= '0;
            rxShift    <= '0;
            rxData     <= '0;
            cnt        <= '0;
            reload     <= 1'b0;
            rxValidReg <= 1'b0;
            misoReg    <= 1'b0;
        end else begin
            rxValidReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (csFall) begin
                        txShift <= txSrc;
                        misoReg <= txSrc[WIDTH-1];
                        cnt     <= '0;
                        reload  <= 1'b0;
                    end else begin
                        misoReg <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (csRise) begin
                        misoReg <= 1'b0;
                    end else if (sclkRise) begin
                        rxShift <= {rxShift[WIDTH-2:0], mosiS};
                        if (cnt == CW'(WIDTH - 1)) begin
                            rxData     <= {rxShift[WIDTH-2:0], mosiS};
                            rxValidReg <= 1'b1;
                            cnt        <= '0;
                            reload     <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else if (sclkFall) begin
                        if (reload) begin
                            txShift <= txSrc;
                            misoReg <= txSrc[WIDTH-1];
                            reload  <= 1'b0;
                        end else begin
                            txShift <= {txShift[WIDTH-2:0], 1'b0};
                            misoReg <= txShift[WIDTH-2];
                        end
                    end
                end
                ABORT: begin
                    cnt     <= '0;
                    rxShift <= '0;
                    reload  <= 1'b0;
                    misoReg <= 1'b0;
                end
                default: misoReg <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table-driven single-word frames plus
// hand-written back-to-back, abort, buffer-reuse and reset sequences.
module tb_spi_slave;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   rxCount = 0;
    logic [7:0] rxLast = 8'h00;
    logic [7:0] rxHist [$];

    spi_slave_if #(.WIDTH(8)) bus ();

    spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Record every rxValid pulse and the word it presents.
    always @(negedge clk) begin
        if (bus.rxValid === 1'b1) begin
            rxCount++;
            rxLast = bus.slaveDataReceived;
            rxHist.push_back(bus.slaveDataReceived);
        end
    end

    typedef struct {
        logic [7:0] txLoad;
        logic [7:0] mosiWord;
        logic [7:0] expMiso;
        logic [7:0] expRx;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doLoad(input logic [7:0] v);
        bus.slaveDataToSend = v;
        bus.load = 1'b1;
        waitClk(1);
        bus.load = 1'b0;
    endtask

    // Clock n bits of w out MSB first (half period 5 clk); MISO sampled just before each rise.
    task automatic sendBits(input logic [7:0] w, input int n, output logic [7:0] misoW);
        misoW = 8'h00;
        for (int i = 0; i < n; i++) begin
            bus.MOSI = w[7-i];
            waitClk(5);
            misoW = {misoW[6:0], bus.MISO};
            bus.SCLK = 1'b1;
            waitClk(5);
            bus.SCLK = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] w, output logic [7:0] misoW);
        bus.CS = 1'b0;
        waitClk(6);
        sendBits(w, 8, misoW);
        waitClk(3);
        bus.CS = 1'b1;
        waitClk(8);
    endtask

    vec_t vecs [4];
    logic [7:0] m, m1, m2;
    int   cnt0;

    initial begin
        vecs[0] = '{8'b00001001, 8'b01010011, 8'b00001001, 8'b01010011};
        vecs[1] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[3] = '{8'hA5, 8'h5A, 8'hA5, 8'h5A};

        // Reset held with a live-looking bus: nothing may come out.
        reset = 1'b1;
        bus.CS = 1'b0; bus.SCLK = 1'b0; bus.MOSI = 1'b1;
        bus.load = 1'b0; bus.slaveDataToSend = 8'h00;
        for (int i = 0; i < 10; i++) begin
            waitClk(5);
            bus.SCLK = ~bus.SCLK;
        end
        check("rst_miso", {31'd0, bus.MISO}, 0);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_rx", {24'd0, bus.slaveDataReceived}, 0);
        check("rst_rxvalid_cnt", rxCount, 0);
        bus.CS = 1'b1; bus.SCLK = 1'b0; bus.MOSI = 1'b0;
        waitClk(4);
        reset = 1'b0;
        waitClk(10);
        check("idle_miso", {31'd0, bus.MISO}, 0);
        check("idle_busy", {31'd0, bus.busy}, 0);

        // Busy follows synchronised CS.
        bus.CS = 1'b0;
        waitClk(4);
        check("busy_on", {31'd0, bus.busy}, 1);
        bus.CS = 1'b1;
        waitClk(8);
        check("busy_off", {31'd0, bus.busy}, 0);

        // Table of single-word frames.
        foreach (vecs[k]) begin
            cnt0 = rxCount;
            doLoad(vecs[k].txLoad);
            frame(vecs[k].mosiWord, m);
            check($sformatf("vec%0d_miso", k), {24'd0, m}, {24'd0, vecs[k].expMiso});
            check($sformatf("vec%0d_rx", k), {24'd0, bus.slaveDataReceived}, {24'd0, vecs[k].expRx});
            check($sformatf("vec%0d_pulses", k), rxCount - cnt0, 1);
            check($sformatf("vec%0d_idle_miso", k), {31'd0, bus.MISO}, 0);
        end

        // Back-to-back words, new load mid-word applies to the second word only.
        cnt0 = rxCount;
        rxHist.delete();
        doLoad(8'b00100010);
        bus.CS = 1'b0;
        waitClk(6);
        fork
            sendBits(8'b00111100, 8, m1);
            begin waitClk(30); doLoad(8'b10000011); end
        join
        sendBits(8'b10011000, 8, m2);
        waitClk(3);
        bus.CS = 1'b1;
        waitClk(8);
        check("b2b_miso1", {24'd0, m1}, {24'd0, 8'b00100010});
        check("b2b_miso2", {24'd0, m2}, {24'd0, 8'b10000011});
        check("b2b_pulses", rxCount - cnt0, 2);
        if (rxHist.size() == 2) begin
            check("b2b_rx1", {24'd0, rxHist[0]}, {24'd0, 8'b00111100});
            check("b2b_rx2", {24'd0, rxHist[1]}, {24'd0, 8'b10011000});
        end else begin
            check("b2b_hist_size", rxHist.size(), 2);
        end

        // Abort after 3 rises: no pulse, output word unchanged.
        cnt0 = rxCount;
        bus.CS = 1'b0;
        waitClk(6);
        sendBits(8'hFF, 3, m);
        waitClk(3);
        bus.CS = 1'b1;
        waitClk(8);
        check("abort_pulses", rxCount - cnt0, 0);
        check("abort_rx_kept", {24'd0, bus.slaveDataReceived}, {24'd0, 8'b10011000});
        check("abort_miso", {31'd0, bus.MISO}, 0);
        frame(8'b10101100, m);
        check("post_abort_pulses", rxCount - cnt0, 1);
        check("post_abort_rx", {24'd0, rxLast}, {24'd0, 8'b10101100});

        // Buffer reused across frames with no reload.
        doLoad(8'b11001001);
        frame(8'h12, m1);
        frame(8'h34, m2);
        check("reuse_miso1", {24'd0, m1}, {24'd0, 8'b11001001});
        check("reuse_miso2", {24'd0, m2}, {24'd0, 8'b11001001});
        check("reuse_rx", {24'd0, bus.slaveDataReceived}, {24'd0, 8'h34});

        // Reset after 5 rises: word lost, everything cleared including TX buffer.
        cnt0 = rxCount;
        bus.CS = 1'b0;
        waitClk(6);
        sendBits(8'hFF, 5, m);
        reset = 1'b1;
        waitClk(2);
        check("midrst_miso", {31'd0, bus.MISO}, 0);
        bus.CS = 1'b1;
        waitClk(2);
        reset = 1'b0;
        waitClk(6);
        check("midrst_rx_cleared", {24'd0, bus.slaveDataReceived}, 0);
        check("midrst_pulses", rxCount - cnt0, 0);
        frame(8'b01100100, m);
        check("after_rst_pulses", rxCount - cnt0, 1);
        check("after_rst_rx", {24'd0, rxLast}, {24'd0, 8'b01100100});
        check("after_rst_miso", {24'd0, m}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
